// File: rtl/branch_comp_pkg.sv
// Shared branch codes, FSM encoding and signedness helper for the iterative branch comparator.
package branch_comp_pkg;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StBusy = ST_BUSY,
        StDone = ST_DONE
    } state_e;

    function automatic logic is_signed(input logic [2:0] f);
        return (f == BR_EQ) || (f == BR_NE) || (f == BR_LT) || (f == BR_GE);
    endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational unsigned equality / less-than on one operand chunk.
module chunk_cmp #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] ca,
    input  logic [CHUNK-1:0] cb,
    output logic             ceq,
    output logic             clt
);

    assign ceq = (ca == cb);
    assign clt = (ca < cb);

endmodule

// File: rtl/branch_comp_iter.sv
// Iterative MSB-first branch comparator, CHUNK bits per beat behind valid/ready.
// Optional early exit on the first differing chunk: define BRANCH_COMP_EARLY_EXIT_EN.
module branch_comp_iter
    import branch_comp_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   funct3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         taken,
    output logic         eq,
    output logic         lt,
    output logic         illegal,
    output logic         busy
);

    localparam int unsigned K    = N / CHUNK;
    localparam int unsigned CntW = (K > 1) ? $clog2(K) : 1;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]      a_q, a_d, b_q, b_d;
    logic [2:0]        f3_q, f3_d;
    logic              diff_q, diff_d;
    logic              lt_q, lt_d;

    logic              accept, last_beat, new_diff, ceq, clt, done;
    logic [N-1:0]      a_sh, b_sh;

    assign in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept   = in_valid && in_ready;

    // Shift the active chunk up to the MSB end so a single comparator serves every beat.
    assign a_sh = a_q << (int'(cnt_q) * CHUNK);
    assign b_sh = b_q << (int'(cnt_q) * CHUNK);

    chunk_cmp #(
        .CHUNK (CHUNK)
    ) u_chunk_cmp (
        .ca  (a_sh[N-1 -: CHUNK]),
        .cb  (b_sh[N-1 -: CHUNK]),
        .ceq (ceq),
        .clt (clt)
    );

    assign last_beat = (cnt_q == CntW'(K - 1));
    assign new_diff  = !diff_q && !ceq;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        f3_d    = f3_q;
        diff_d  = diff_q;
        lt_d    = lt_q;
        unique case (state_q)
            StIdle: ;
            StBusy: begin
                cnt_d = cnt_q + 1'b1;
                if (new_diff) begin
                    diff_d = 1'b1;
                    lt_d   = clt;
                end
`ifdef BRANCH_COMP_EARLY_EXIT_EN
                if (last_beat || new_diff) begin
`else
                if (last_beat) begin
`endif
                    state_d = StDone;
                    cnt_d   = '0;
                end
            end
            StDone: begin
                if (out_ready && !in_valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Flipping the sign bit turns two's-complement order into unsigned order.
        if (accept) begin
            state_d = StBusy;
            cnt_d   = '0;
            a_d     = a ^ {is_signed(funct3), {(N-1){1'b0}}};
            b_d     = b ^ {is_signed(funct3), {(N-1){1'b0}}};
            f3_d    = funct3;
            diff_d  = 1'b0;
            lt_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            f3_q    <= '0;
            diff_q  <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f3_q    <= f3_d;
            diff_q  <= diff_d;
            lt_q    <= lt_d;
        end
    end

    assign done      = (state_q == StDone);
    assign out_valid = done;
    assign busy      = (state_q == StBusy);
    assign eq        = done && !diff_q;
    assign lt        = done && lt_q;
    assign illegal   = done && ((f3_q == 3'b010) || (f3_q == 3'b011));

    always_comb begin
        taken = 1'b0;
        if (done) begin
            case (f3_q)
                BR_EQ:          taken = !diff_q;
                BR_NE:          taken = diff_q;
                BR_LT, BR_LTU:  taken = lt_q;
                BR_GE, BR_GEU:  taken = !lt_q;
                default:        taken = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_comp_iter.sv
// Randomized and directed self-checking bench for branch_comp_iter (N=32, CHUNK=8).
module tb_branch_comp_iter;

    localparam int N = 32;
    localparam int CHUNK = 8;
    localparam int K = N / CHUNK;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  funct3;
    logic        out_valid;
    logic        out_ready;
    logic        taken;
    logic        eq;
    logic        lt;
    logic        illegal;
    logic        busy;

    int n_pass = 0;
    int n_total = 0;

    branch_comp_iter #(
        .N     (N),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .funct3    (funct3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .taken     (taken),
        .eq        (eq),
        .lt        (lt),
        .illegal   (illegal),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: {taken, eq, lt, illegal} straight from the RV32I branch semantics.
    function automatic logic [3:0] ref_result(input logic [31:0] x, input logic [31:0] y,
                                              input logic [2:0] f);
        logic r_eq, r_lt, r_ill, r_tk, sgn;
        r_eq  = (x == y);
        sgn   = (f == 3'b000) || (f == 3'b001) || (f == 3'b100) || (f == 3'b101);
        r_lt  = sgn ? ($signed(x) < $signed(y)) : (x < y);
        r_ill = (f == 3'b010) || (f == 3'b011);
        case (f)
            3'b000:         r_tk = r_eq;
            3'b001:         r_tk = !r_eq;
            3'b100, 3'b110: r_tk = r_lt;
            3'b101, 3'b111: r_tk = !r_lt;
            default:        r_tk = 1'b0;
        endcase
        return {r_tk, r_eq, r_lt, r_ill};
    endfunction

    // Edges counted from the accept edge (inclusive) until out_valid is seen.
    function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y);
`ifdef BRANCH_COMP_EARLY_EXIT_EN
        logic [31:0] d;
        d = x ^ y;
        if (d == 32'd0) return K + 1;
        for (int i = 31; i >= 0; i--) begin
            if (d[i]) return (31 - i) / CHUNK + 2;
        end
        return K + 1;
`else
        return K + 1 + 0 * int'(x[0] ^ y[0]);
`endif
    endfunction

    task automatic run_op(input logic [31:0] ai, input logic [31:0] bi, input logic [2:0] f,
                          output int lat);
        @(negedge clk);
        a = ai;
        b = bi;
        funct3 = f;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        funct3 = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        funct3 = '0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({out_valid, taken, eq, lt, illegal, busy, in_ready} !== 7'b0000001)
            $display("FAIL reset_outputs got=%b exp=%b",
                     {out_valid, taken, eq, lt, illegal, busy, in_ready}, 7'b0000001);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] va[6] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'h8000_0000, 32'h0000_0001};
        logic [31:0] vb[6] = '{32'h1234_5678, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001,
                                32'h0000_0000, 32'h0000_0002};
        logic [2:0]  vf[6] = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b101, 3'b110};
        int lat;
        logic [3:0] exp;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vf[i], lat);
            exp = ref_result(va[i], vb[i], vf[i]);
            n_total++;
            if ({taken, eq, lt, illegal} !== exp)
                $display("FAIL directed_%0d_result got=%b exp=%b", i, {taken, eq, lt, illegal}, exp);
            else n_pass++;
            n_total++;
            if (lat !== ref_lat(va[i], vb[i]))
                $display("FAIL directed_%0d_latency got=%0d exp=%0d", i, lat, ref_lat(va[i], vb[i]));
            else n_pass++;
            release_op();
        end
    endtask

    task automatic test_random();
        logic [2:0] codes[6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        logic [31:0] ra, rb;
        logic [2:0] rf;
        logic [3:0] exp;
        int lat;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = ra;
            for (int c = 0; c < K; c++) begin
                if ($urandom_range(0, 2) == 0) rb[c*CHUNK +: CHUNK] = 8'($urandom);
            end
            rf = codes[$urandom_range(0, 5)];
            run_op(ra, rb, rf, lat);
            exp = ref_result(ra, rb, rf);
            n_total++;
            if ({taken, eq, lt, illegal} !== exp)
                $display("FAIL random_%0d_result a=%h b=%h f=%b got=%b exp=%b",
                         i, ra, rb, rf, {taken, eq, lt, illegal}, exp);
            else n_pass++;
            n_total++;
            if (lat !== ref_lat(ra, rb))
                $display("FAIL random_%0d_latency got=%0d exp=%0d", i, lat, ref_lat(ra, rb));
            else n_pass++;
            release_op();
        end
    endtask

    task automatic test_backpressure_illegal();
        logic [31:0] ra, rb;
        logic exp_eq;
        int lat;
        ra = $urandom;
        rb = ($urandom_range(0, 1) == 0) ? ra : $urandom;
        exp_eq = (ra == rb);
        run_op(ra, rb, 3'b011, lat);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            n_total++;
            if ({out_valid, taken, eq, illegal} !== {1'b1, 1'b0, exp_eq, 1'b1})
                $display("FAIL illegal_hold_%0d got=%b exp=%b", c,
                         {out_valid, taken, eq, illegal}, {1'b1, 1'b0, exp_eq, 1'b1});
            else n_pass++;
        end
    endtask

    // Entered with a result pending in DONE.
    task automatic test_back_to_back();
        logic [31:0] ra, rb;
        logic [3:0] exp;
        int lat;
        ra = 32'h0000_0005;
        rb = 32'hFFFF_FFFB;
        @(negedge clk);
        a = ra;
        b = rb;
        funct3 = 3'b100;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL b2b_in_ready got=%b exp=1", in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_total++;
        if ({busy, out_valid} !== 2'b10)
            $display("FAIL b2b_accept got=%b exp=10", {busy, out_valid});
        else n_pass++;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        exp = ref_result(ra, rb, 3'b100);
        n_total++;
        if ({taken, eq, lt, illegal} !== exp)
            $display("FAIL b2b_result got=%b exp=%b", {taken, eq, lt, illegal}, exp);
        else n_pass++;
        n_total++;
        if (lat !== ref_lat(ra, rb))
            $display("FAIL b2b_latency got=%0d exp=%0d", lat, ref_lat(ra, rb));
        else n_pass++;
        release_op();
    endtask

    task automatic test_mid_reset();
        int lat;
        logic [3:0] exp;
        @(negedge clk);
        a = 32'hFFFF_FFFF;
        b = 32'h0000_0000;
        funct3 = 3'b110;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if ({out_valid, busy, in_ready, eq, lt} !== 5'b00100)
            $display("FAIL mid_reset got=%b exp=%b", {out_valid, busy, in_ready, eq, lt}, 5'b00100);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        run_op(32'h0000_0001, 32'h0000_0001, 3'b000, lat);
        exp = ref_result(32'h0000_0001, 32'h0000_0001, 3'b000);
        n_total++;
        if ({taken, eq, lt, illegal} !== exp)
            $display("FAIL post_reset_result got=%b exp=%b", {taken, eq, lt, illegal}, exp);
        else n_pass++;
        n_total++;
        if (lat !== K + 1) $display("FAIL post_reset_latency got=%0d exp=%0d", lat, K + 1);
        else n_pass++;
        release_op();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure_illegal();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/branch_comp_iter.md
Name: branch_comp_iter

Overview:
- Iterative, parametrised branch comparator for the RV32I branch unit. It resolves beq/bne/blt/bge/bltu/bgeu.
- Compares two N-bit operands MSB-first, CHUNK bits per cycle, behind a valid/ready handshake.
- Supersedes the single-cycle comparator on timing-critical builds: area/latency trade-off through CHUNK.
- Produces a taken flag plus raw eq/lt status for the branch/PC-select logic.

Parameters:
- N, 32, operand width; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; K = N/CHUNK beats.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- a  input  N  operand rs1.
- b  input  N  operand rs2.
- funct3  input  3  branch code: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu.
- out_valid  output  1  result valid, held until out_ready.
- out_ready  input  1  consumer accepts result.
- taken  output  1  branch condition true.
- eq  output  1  a == b.
- lt  output  1  a < b, signed or unsigned per funct3.
- illegal  output  1  funct3 is 010 or 011.
- busy  output  1  state is BUSY.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state=IDLE, out_valid=0, taken=0, eq=0, lt=0, illegal=0, busy=0, beat counter=0.
- States and transitions:
  - IDLE -> BUSY on accept.
  - BUSY -> DONE after the final beat.
  - DONE -> IDLE on out_ready && !in_valid.
  - DONE -> BUSY on out_ready && in_valid (back-to-back accept).
- in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational from state and out_ready only, never from in_valid.
- Operand capture on accept: a, b and funct3 are registered. For signed codes (000, 001, 100, 101), the MSB of both captured operands is inverted, so all later comparison is unsigned. Eq is unaffected by this inversion.
- BUSY beat i (i=0..K-1): compare chunk [N-1-i*CHUNK -: CHUNK] of the captured operands.
  - Running flags: diff_seen and lt_acc.
  - On the first differing chunk, set diff_seen=1 and lt_acc = chunk_a < chunk_b.
  - Later chunks never modify lt_acc.
- Default latency: exactly K BUSY cycles. out_valid rises on the clock edge after the last beat, K+1 edges after accept. With N=32, CHUNK=8, out_valid is high 5 cycles after the accept edge.
- DONE outputs:
  - eq = !diff_seen; lt = lt_acc.
  - taken: eq→eq, ne→!eq, lt/ltu→lt, ge/geu→!lt.
  - Illegal codes: illegal=1, taken=0, eq and lt still reported.
- Outputs are stable while out_valid && !out_ready.
- Inputs a, b and funct3 are ignored while not accepting.
- reset asserted in any state: aborts the operation, returns to IDLE next edge, and applies the reset values. The in-flight result is discarded.

Optional Feature:
- Macro: BRANCH_COMP_EARLY_EXIT_EN.
- Defined: BUSY moves to DONE on the beat where the first differing chunk is found. Latency is variable, 1..K beats; equal operands still take K beats.
- Undefined: constant K-beat latency regardless of data.
- Result values are identical in both builds.

Decomposition:
- Package branch_comp_pkg:
  - funct3 localparams BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU.
  - state encoding IDLE/BUSY/DONE as a 2-bit localparam set.
  - function is_signed(funct3).
- Sub-module chunk_cmp #(CHUNK): combinational, inputs ca and cb, outputs ceq and clt (unsigned).
  - Instantiated once and multiplexed by the beat counter.

Test Plan (N=32, CHUNK=8):
- Equal operands: a=b=0x1234_5678, funct3=000, out_ready=1 → taken=1, eq=1, lt=0, illegal=0, out_valid 5 cycles after accept in both builds.
- Signed vs unsigned ordering:
  - a=0xFFFF_FFFF, b=0x0000_0001, funct3=100 → taken=1 (−1<1).
  - Same operands, funct3=110 → taken=0, lt=0.
  - Same operands, funct3=111 → taken=1.
- Early-exit latency: a=0x8000_0000, b=0x0000_0000, funct3=101 → taken=0. With BRANCH_COMP_EARLY_EXIT_EN, out_valid 2 cycles after accept; without, 5 cycles.
- Difference in the last chunk only: a=0x0000_0001, b=0x0000_0002, funct3=110 → taken=1. 5-cycle latency in both builds; the early-MSB lt_acc is not overwritten.
- Illegal code with back-pressure: funct3=011, out_ready=0 for 3 cycles → out_valid held, illegal=1, taken=0, outputs stable. Next request with in_valid=1 and out_ready=1 in DONE is accepted the same cycle (back-to-back).
- Mid-operation reset: assert reset on beat 2 → next edge IDLE, out_valid=0, in_ready=1. A new request afterwards completes correctly with no stale lt or eq.
